// File: rtl/mac_params.sv
// Shared MAC transmit-path constants: symbol geometry, idle fill and buffer depth.
package mac_params;
  localparam int MAC_TX_BUF_DEPTH = 8;
  localparam int N_CHANNELS       = 4;
  localparam int W_BYTE           = 8;
  localparam logic [W_BYTE-1:0] SYM_IDLE = 8'h07;
  // One stored entry: a control bit per channel on top of the data bytes.
  localparam int W_ENTRY = N_CHANNELS * (W_BYTE + 1);
endpackage

// File: rtl/mac_tx_buf_if.sv
// Write/read handshake and status bundle between a TX producer, the buffer and framegen.
interface mac_tx_buf_if import mac_params::*; #(
  parameter int DEPTH = MAC_TX_BUF_DEPTH
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic                               i_wen;
  logic [N_CHANNELS-1:0]              i_wctrl;
  logic [N_CHANNELS-1:0][W_BYTE-1:0]  i_wdata;
  logic                               i_ren;
  logic [N_CHANNELS-1:0]              o_rctrl;
  logic [N_CHANNELS-1:0][W_BYTE-1:0]  o_rdata;
  logic                               o_empty;
  logic                               o_full;
  logic                               o_almost_full;
  logic [PW-1:0]                      o_count;
  logic                               o_overflow;
  logic                               o_underflow;

  modport master (
    output i_wen, i_wctrl, i_wdata, i_ren,
    input  o_rctrl, o_rdata, o_empty, o_full, o_almost_full, o_count,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_wen, i_wctrl, i_wdata, i_ren,
    output o_rctrl, o_rdata, o_empty, o_full, o_almost_full, o_count,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/mac_tx_buf_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module mac_tx_buf_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 36
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/mac_tx_buf.sv
// First-word-fall-through TX buffer between the MAC encoder and framegen; shows idle
// symbols while empty and keeps sticky overflow/underflow flags.
module mac_tx_buf import mac_params::*; #(
  parameter int DEPTH = MAC_TX_BUF_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic        i_clear,
  mac_tx_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      wptr, rptr, count;
  logic               empty, full;
  logic               wr_ok, rd_ok, mem_we;
  logic               overflow, underflow;
  logic [W_ENTRY-1:0] mem_wdata, mem_rdata;

  // Status comes from the registered pointers only, never from this cycle's requests.
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A read frees the slot while full, so a simultaneous write still lands.
  assign wr_ok  = bus.i_wen && (!full || bus.i_ren);
  assign rd_ok  = bus.i_ren && !empty;
  assign mem_we = i_clk_en && !i_reset && !i_clear && wr_ok;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (i_clk_en) begin
      if (i_clear) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + PW'(1);
        if (rd_ok) rptr <= rptr + PW'(1);
        if (bus.i_wen && full && !bus.i_ren) overflow  <= 1'b1;
        if (bus.i_ren && empty)              underflow <= 1'b1;
      end
    end
  end

  assign mem_wdata = {bus.i_wctrl, bus.i_wdata};

  mac_tx_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (W_ENTRY)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wptr[AW-1:0]),
    .i_wdata (mem_wdata),
    .i_raddr (rptr[AW-1:0]),
    .o_rdata (mem_rdata)
  );

  // Per channel: head entry when occupied, idle control symbol otherwise.
  for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_ch
    assign bus.o_rctrl[ch] = empty | mem_rdata[N_CHANNELS*W_BYTE + ch];
    assign bus.o_rdata[ch] = empty ? SYM_IDLE : mem_rdata[ch*W_BYTE +: W_BYTE];
  end

  assign bus.o_empty       = empty;
  assign bus.o_full        = full;
  assign bus.o_almost_full = (count >= PW'(DEPTH - 2));
  assign bus.o_count       = count;
  assign bus.o_overflow    = overflow;
  assign bus.o_underflow   = underflow;
endmodule

// File: tb/tb_mac_tx_buf.sv
// Bench for mac_tx_buf: directed table, corner sequences and random traffic against a queue model.
module tb_mac_tx_buf;
  import mac_params::*;

  localparam int DEPTH = 8;
  localparam logic [35:0] IDLE = {4'hF, 32'h0707_0707};

  logic i_clk = 1'b0;
  logic i_reset, i_clk_en, i_clear;
  int   n_chk = 0;
  int   n_err = 0;

  mac_tx_buf_if #(.DEPTH(DEPTH)) bus ();

  mac_tx_buf #(.DEPTH(DEPTH)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clk_en (i_clk_en),
    .i_clear  (i_clear),
    .bus      (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a queue of {ctrl,data} entries plus the two sticky flags.
  logic [35:0] q[$];
  logic        m_ovf, m_udf;

  function automatic logic [35:0] m_head();
    return (q.size() == 0) ? IDLE : q[0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("count",  64'(bus.o_count), 64'(q.size()));
    chk("empty",  64'(bus.o_empty), 64'(q.size() == 0));
    chk("full",   64'(bus.o_full),  64'(q.size() == DEPTH));
    chk("afull",  64'(bus.o_almost_full), 64'(q.size() >= DEPTH - 2));
    chk("ovf",    64'(bus.o_overflow),  64'(m_ovf));
    chk("udf",    64'(bus.o_underflow), 64'(m_udf));
    chk("head",   64'({bus.o_rctrl, bus.o_rdata}), 64'(m_head()));
  endtask

  // Apply one cycle of inputs, advance the model on the same edge, then compare.
  task automatic step(input logic rst, en, clr, wen, ren,
                      input logic [3:0] wc, input logic [31:0] wd);
    i_reset = rst; i_clk_en = en; i_clear = clr;
    bus.i_wen = wen; bus.i_ren = ren; bus.i_wctrl = wc; bus.i_wdata = wd;
    @(posedge i_clk);
    if (rst) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else if (en) begin
      if (clr) q.delete();
      else begin
        if (ren && q.size() == 0) m_udf = 1'b1;
        if (wen && q.size() == DEPTH && !ren) m_ovf = 1'b1;
        if (ren && q.size() > 0) void'(q.pop_front());
        if (wen && q.size() < DEPTH) q.push_back({wc, wd});
      end
    end
    #1;
    check_model();
  endtask

  typedef struct {
    logic        en, clr, wen, ren;
    logic [3:0]  wc;
    logic [31:0] wd;
    int          cnt;
    logic        emp, udf;
    logic [35:0] head;
  } vec_t;

  vec_t tbl[11];
  logic [35:0] ent[12];

  initial begin
    tbl[0]  = '{1,0,1,0,4'h0,32'h04030201, 1,0,0, 36'h0_0403_0201};
    tbl[1]  = '{1,0,1,0,4'h0,32'h08070605, 2,0,0, 36'h0_0403_0201};
    tbl[2]  = '{1,0,1,0,4'h0,32'h0C0B0A09, 3,0,0, 36'h0_0403_0201};
    tbl[3]  = '{1,0,0,1,4'h0,32'h0,        2,0,0, 36'h0_0807_0605};
    tbl[4]  = '{1,0,0,1,4'h0,32'h0,        1,0,0, 36'h0_0C0B_0A09};
    tbl[5]  = '{1,0,0,1,4'h0,32'h0,        0,1,0, IDLE};
    tbl[6]  = '{1,0,0,1,4'h0,32'h0,        0,1,1, IDLE};
    tbl[7]  = '{0,0,1,0,4'h5,32'h11223344, 0,1,1, IDLE};
    tbl[8]  = '{1,0,1,1,4'h5,32'h11223344, 1,0,1, 36'h5_1122_3344};
    tbl[9]  = '{0,0,0,1,4'h0,32'h0,        1,0,1, 36'h5_1122_3344};
    tbl[10] = '{1,1,1,0,4'h3,32'hDEADBEEF, 0,1,1, IDLE};

    step(1, 0, 0, 0, 0, 4'h0, 32'h0);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_head",  64'({bus.o_rctrl, bus.o_rdata}), 64'(IDLE));

    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].en, tbl[i].clr, tbl[i].wen, tbl[i].ren, tbl[i].wc, tbl[i].wd);
      chk($sformatf("tbl%0d_count", i), 64'(bus.o_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 64'(bus.o_empty), 64'(tbl[i].emp));
      chk($sformatf("tbl%0d_udf", i),   64'(bus.o_underflow), 64'(tbl[i].udf));
      chk($sformatf("tbl%0d_head", i),  64'({bus.o_rctrl, bus.o_rdata}), 64'(tbl[i].head));
    end

    // Fill, overflow by one, drain in order.
    step(1, 1, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 12; i++) ent[i] = {4'($urandom), 32'($urandom)};
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 0, ent[i][35:32], ent[i][31:0]);
    chk("fill_full", 64'(bus.o_full), 64'd1);
    step(0, 1, 0, 1, 0, 4'hA, 32'hBAD0BAD0);
    chk("ovf_set",   64'(bus.o_overflow), 64'd1);
    chk("ovf_count", 64'(bus.o_count), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), 64'({bus.o_rctrl, bus.o_rdata}), 64'(ent[i]));
      step(0, 1, 0, 0, 1, 4'h0, 32'h0);
    end
    chk("drain_empty", 64'(bus.o_empty), 64'd1);

    // Full with simultaneous read+write across the pointer wrap.
    step(1, 1, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 0, ent[i][35:32], ent[i][31:0]);
    for (int i = 8; i < 12; i++) begin
      step(0, 1, 0, 1, 1, ent[i][35:32], ent[i][31:0]);
      chk("rw_full_count", 64'(bus.o_count), 64'd8);
      chk("rw_full_ovf",   64'(bus.o_overflow), 64'd0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("wrap%0d", i), 64'({bus.o_rctrl, bus.o_rdata}), 64'(ent[4+i]));
      step(0, 1, 0, 0, 1, 4'h0, 32'h0);
    end

    // Underflow, then clear over held entries keeps sticky flags.
    step(0, 1, 0, 0, 1, 4'h0, 32'h0);
    chk("udf_set", 64'(bus.o_underflow), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 4'h0, 32'(i));
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 1, 4'h1, 32'h55AA55AA);
      chk("clr_empty", 64'(bus.o_empty), 64'd1);
      chk("clr_udf",   64'(bus.o_underflow), 64'd1);
    end

    // Reset with the clock enable low still discards everything.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 4'h0, 32'(i));
    step(1, 0, 0, 0, 0, 4'h0, 32'h0);
    chk("rst_noen_count", 64'(bus.o_count), 64'd0);
    chk("rst_noen_udf",   64'(bus.o_underflow), 64'd0);

    // Random traffic with enable gaps, clears and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 45,
           4'($urandom), 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_tx_buf.md
MAC_TX_BUF -- requirements
Module: mac_tx_buf

Interface
REQ-001 Parameter DEPTH, default MAC_TX_BUF_DEPTH (8), number of entries; a power of two, at least 4.
REQ-002 i_clk  in  1  clock; all logic on rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_clk_en  in  1  cycle qualifier; state changes only when high.
REQ-005 i_clear  in  1  flush all entries.
REQ-006 i_wen  in  1  write one entry.
REQ-007 i_wctrl  in  N_CHANNELS  per-byte control flag of the write entry.
REQ-008 i_wdata  in  N_CHANNELS x W_BYTE  write bytes.
REQ-009 i_ren  in  1  consume head entry (framegen read).
REQ-010 o_rctrl  out  N_CHANNELS  head entry control flags.
REQ-011 o_rdata  out  N_CHANNELS x W_BYTE  head entry bytes.
REQ-012 o_empty  out  1  no entries held.
REQ-013 o_full  out  1  DEPTH entries held.
REQ-014 o_almost_full  out  1  count >= DEPTH-2.
REQ-015 o_count  out  clog2(DEPTH)+1  occupancy.
REQ-016 o_overflow  out  1  sticky: a write was dropped.
REQ-017 o_underflow  out  1  sticky: a read hit an empty buffer.

Function
REQ-018 The buffer SHALL be first-word-fall-through: o_rctrl/o_rdata show the head entry combinationally whenever o_empty=0.
REQ-019 While o_empty=1, o_rctrl SHALL be all ones and every o_rdata byte SHALL be SYM_IDLE.
REQ-020 Writes and reads SHALL take effect only on edges with i_clk_en=1; with i_clk_en=0 all state SHALL hold.
REQ-021 An accepted write SHALL store {i_wctrl,i_wdata} at the write pointer; the entry becomes visible at the head no earlier than the next cycle (write-to-read latency 1).
REQ-022 An accepted read SHALL advance the read pointer; the next entry SHALL appear on o_rdata in the following cycle.
REQ-023 Pointers SHALL be clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-024 o_count SHALL equal wptr-rptr (modulo 2*DEPTH), and o_empty/o_full/o_almost_full SHALL derive from registered pointers only.
REQ-025 Read and write in the same cycle while full: both SHALL be accepted; count unchanged.
REQ-026 Read and write in the same cycle while empty: the write SHALL be accepted, the read ignored, and o_underflow SHALL be set.
REQ-027 Write while full without read: the write SHALL be dropped, contents unchanged, and o_overflow SHALL be set.
REQ-028 Read while empty without write: no pointer change; o_underflow SHALL be set.
REQ-029 i_clear (with i_clk_en=1) SHALL override i_wen/i_ren in the same cycle; both pointers go to 0; o_empty=1 from the next cycle.
REQ-030 i_clear SHALL NOT clear o_overflow/o_underflow; only i_reset does.
REQ-031 i_clear may be held high for many cycles; the buffer SHALL remain empty throughout.

Reset
REQ-032 On i_reset, independent of i_clk_en: pointers 0, o_empty=1, o_full=0, o_almost_full=0, o_count=0, o_overflow=0, o_underflow=0, o_rctrl all ones, o_rdata all SYM_IDLE.
REQ-033 Reset mid-frame SHALL discard all held entries; memory contents need no reset.

Structure
REQ-034 MAC_TX_BUF_DEPTH, SYM_IDLE, N_CHANNELS and W_BYTE SHALL reside in mac_params; no new local typedefs for bus shapes.
REQ-035 Storage SHALL be a sub-module mac_tx_buf_mem: simple dual-port, synchronous write, asynchronous read, width N_CHANNELS*(W_BYTE+1), no reset.

Verification
REQ-036 Write 3 entries (ctrl 0, data 0x01..0x0C) then read 3 -> data returned in order, o_count 1,2,3 then 2,1,0, o_empty=1 after the last read.
REQ-037 Fill DEPTH=8, write a 9th -> o_full=1, o_overflow=1, and reading 8 returns the first 8 entries unchanged.
REQ-038 When full, assert i_wen and i_ren together for 4 cycles -> o_count stays 8, no overflow, FIFO order preserved across pointer wrap.
REQ-039 When empty, assert i_ren alone -> o_underflow=1, o_rdata=0x07 x4, o_rctrl=4'b1111, pointers unchanged.
REQ-040 Hold 5 entries, assert i_clear with i_wen=1 -> next cycle o_empty=1, o_count=0, new data not stored, sticky flags retained.
REQ-041 Toggle i_clk_en low during a write/read burst -> no state change on disabled cycles; sequence is identical to the burst with i_clk_en held high.
